// File: rtl/hardwired_control_unit.sv
// hardwired_control_unit: Moore FSM sequencing fetch and execute strobes for the DataPath
module hardwired_control_unit #(
    parameter int OPW         = 5,
    parameter int NREG        = 16,
    parameter int RD_WAIT_MAX = 15
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            IncPC,
    output logic            Read,
    output logic            HIin,
    output logic            LOin,
    output logic            ZHighIn,
    output logic            ZLowIn,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [OPW-1:0]  opcode,
    output logic            instr_done,
    output logic            halted,
    output logic            fault
);
    localparam int CW = $clog2(RD_WAIT_MAX + 1);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_HALT  = 4'd8;
    localparam logic [3:0] S_FAULT = 4'd9;
    localparam logic [NREG-1:0] ONE = NREG'(1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OPW-1:0] op;
    logic [3:0]    ra, rb, rc;
    logic          is_a3, is_two, is_mul, is_nop, is_halt;
    logic [3:0]    done_next;
    logic          unused_ir;

    assign op        = ir[31 -: OPW];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign is_a3     = op >= OPW'(3) && op <= OPW'(11);
    assign is_two    = op == OPW'(17) || op == OPW'(18);
    assign is_mul    = op == OPW'(15) || op == OPW'(16);
    assign is_nop    = op == OPW'(26);
    assign is_halt   = op == OPW'(27);
    assign done_next = run ? S_T0 : S_IDLE;

    // next-state and T1 wait counter; counter is zero outside a T1 wait
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE:  state_d = run ? S_T0 : S_IDLE;
            S_T0:    state_d = S_T1;
            S_T1: begin
                if (mem_ready) state_d = S_T2;
                else if (cnt_q == CW'(RD_WAIT_MAX - 1)) state_d = S_FAULT;
                else cnt_d = cnt_q + CW'(1);
            end
            S_T2:    state_d = S_T3;
            S_T3:    state_d = (is_a3 || is_two || is_mul) ? S_T4 : is_nop ? done_next : is_halt ? S_HALT : S_FAULT;
            S_T4:    state_d = (is_a3 || is_mul) ? S_T5 : is_two ? done_next : S_FAULT;
            S_T5:    state_d = is_a3 ? done_next : is_mul ? S_T6 : S_FAULT;
            S_T6:    state_d = done_next;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // state register with asynchronous clear
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode from state and the instruction class
    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin} = '0;
        {Yin, IncPC, Read, HIin, LOin, ZHighIn, ZLowIn} = '0;
        Rin        = '0;
        Rout       = '0;
        opcode     = '0;
        instr_done = 1'b0;
        halted     = state_q == S_HALT;
        fault      = state_q == S_FAULT;
        case (state_q)
            S_T0: {PCout, MARin, IncPC, PCin} = 4'b1111;
            S_T1: {Read, MDRin} = 2'b11;
            S_T2: {MDRout, IRin} = 2'b11;
            S_T3: begin
                Rout       = is_a3 ? ONE << rc : is_two ? ONE << rb : is_mul ? ONE << ra : '0;
                Yin        = is_a3 || is_mul;
                opcode     = is_two ? op : '0;
                ZLowIn     = is_two;
                instr_done = is_nop;
            end
            S_T4: begin
                Rout       = (is_a3 || is_mul) ? ONE << rb : '0;
                opcode     = (is_a3 || is_mul) ? op : '0;
                ZLowIn     = is_a3 || is_mul;
                ZHighIn    = is_mul;
                Zlowout    = is_two;
                Rin        = is_two ? ONE << ra : '0;
                instr_done = is_two;
            end
            S_T5: begin
                Zlowout    = is_a3 || is_mul;
                Rin        = is_a3 ? ONE << ra : '0;
                LOin       = is_mul;
                instr_done = is_a3;
            end
            S_T6: {Zhighout, HIin, instr_done} = 3'b111;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_hardwired_control_unit.sv
// tb_hardwired_control_unit: randomized checks against a micro-step list model of the control unit
module tb_hardwired_control_unit;
    localparam int NREG = 16;
    localparam int OPW  = 5;
    localparam int RDW  = 15;
    localparam logic [54:0] PCOUT = 55'h1 << 54;
    localparam logic [54:0] ZHO   = 55'h1 << 53;
    localparam logic [54:0] ZLO   = 55'h1 << 52;
    localparam logic [54:0] MDRO  = 55'h1 << 51;
    localparam logic [54:0] MARIN = 55'h1 << 50;
    localparam logic [54:0] PCIN  = 55'h1 << 49;
    localparam logic [54:0] MDRIN = 55'h1 << 48;
    localparam logic [54:0] IRIN  = 55'h1 << 47;
    localparam logic [54:0] YIN   = 55'h1 << 46;
    localparam logic [54:0] INCPC = 55'h1 << 45;
    localparam logic [54:0] READ  = 55'h1 << 44;
    localparam logic [54:0] HIIN  = 55'h1 << 43;
    localparam logic [54:0] LOIN  = 55'h1 << 42;
    localparam logic [54:0] ZHIN  = 55'h1 << 41;
    localparam logic [54:0] ZLIN  = 55'h1 << 40;
    localparam logic [54:0] DONE  = 55'h1 << 2;
    localparam logic [54:0] HALTD = 55'h1 << 1;
    localparam logic [54:0] FLT   = 55'h1;

    logic clock = 0, clear = 0, run = 0, mem_ready = 0;
    logic [31:0] ir = '0;
    logic PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic HIin, LOin, ZHighIn, ZLowIn, instr_done, halted, fault;
    logic [NREG-1:0] Rin, Rout;
    logic [OPW-1:0] opcode;
    logic [54:0] obs;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [54:0] v;
        logic        mr;
    } step_t;
    step_t q[$];

    hardwired_control_unit #(.OPW(OPW), .NREG(NREG), .RD_WAIT_MAX(RDW)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
        .Read(Read), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .Rin(Rin), .Rout(Rout), .opcode(opcode), .instr_done(instr_done),
        .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    assign obs = {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read,
                  HIin, LOin, ZHighIn, ZLowIn, Rin, Rout, opcode, instr_done, halted, fault};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [54:0] rin(input logic [3:0] n);
        return 55'h1 << (24 + n);
    endfunction

    function automatic logic [54:0] rout(input logic [3:0] n);
        return 55'h1 << (8 + n);
    endfunction

    function automatic logic [54:0] opc(input logic [4:0] op);
        return 55'(op) << 3;
    endfunction

    // 0 three-operand, 1 two-operand, 2 mul/div, 3 nop, 4 halt, 5 illegal
    function automatic int kind(input logic [4:0] op);
        if (op inside {[5'd3:5'd11]}) return 0;
        if (op inside {5'd17, 5'd18}) return 1;
        if (op inside {5'd15, 5'd16}) return 2;
        if (op == 5'd26) return 3;
        if (op == 5'd27) return 4;
        return 5;
    endfunction

    task automatic push(input logic [54:0] v, input logic mr);
        step_t s;
        s.v  = v;
        s.mr = mr;
        q.push_back(s);
    endtask

    // expected per-cycle output list for one instruction starting at T0
    task automatic build(input logic [31:0] v, input int waits);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = v[31:27];
        ra = v[26:23];
        rb = v[22:19];
        rc = v[18:15];
        q.delete();
        push(PCOUT | MARIN | INCPC | PCIN, 1'b1);
        if (waits >= RDW) begin
            repeat (RDW) push(READ | MDRIN, 1'b0);
            repeat (4) push(FLT, 1'b0);
            return;
        end
        repeat (waits) push(READ | MDRIN, 1'b0);
        push(READ | MDRIN, 1'b1);
        push(MDRO | IRIN, 1'b1);
        case (kind(op))
            0: begin
                push(rout(rc) | YIN, 1'b1);
                push(rout(rb) | opc(op) | ZLIN, 1'b1);
                push(ZLO | rin(ra) | DONE, 1'b1);
            end
            1: begin
                push(rout(rb) | opc(op) | ZLIN, 1'b1);
                push(ZLO | rin(ra) | DONE, 1'b1);
            end
            2: begin
                push(rout(ra) | YIN, 1'b1);
                push(rout(rb) | opc(op) | ZHIN | ZLIN, 1'b1);
                push(ZLO | LOIN, 1'b1);
                push(ZHO | HIIN | DONE, 1'b1);
            end
            3: push(DONE, 1'b1);
            4: begin
                push('0, 1'b1);
                repeat (4) push(HALTD, 1'b1);
            end
            default: begin
                push('0, 1'b1);
                repeat (4) push(FLT, 1'b1);
            end
        endcase
    endtask

    // run one instruction; drop = step where run falls, abort = step after which clear falls
    task automatic exec(input logic [31:0] v, input int waits, input int drop, input int abort, input string name);
        build(v, waits);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clock);
            ir = v;
            checks++;
            if (obs !== q[i].v) begin
                errors++;
                $display("FAIL %s step %0d: got %h, expected %h", name, i, obs, q[i].v);
            end
            checks++;
            if (!$onehot0(obs[39:24]) || !$onehot0(obs[23:8]) || $countones({obs[54:51], obs[23:8]}) > 1) begin
                errors++;
                $display("FAIL %s step %0d invariant: got %h, expected one-hot Rin/Rout and one bus driver", name, i, obs);
            end
            mem_ready = q[i].mr;
            run = (drop < 0 || i < drop);
            if (i == abort) begin
                #2 clear = 0;
                #1 checks++;
                if (obs !== '0) begin
                    errors++;
                    $display("FAIL %s async clear: got %h, expected 0", name, obs);
                end
                return;
            end
        end
    endtask

    task automatic do_reset(input logic run_v, input string name);
        @(negedge clock);
        clear = 0;
        @(negedge clock);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s reset outputs: got %h, expected 0", name, obs);
        end
        @(negedge clock);
        clear = 1;
        run = run_v;
    endtask

    task automatic check_idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL %s idle cycle %0d: got %h, expected 0", name, i, obs);
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0, "reset");
        check_idle(3, "reset_idle");
        run = 1;
    endtask

    task automatic test_shl();
        exec(32'h5A1B8000, 0, -1, -1, "shl");
    endtask

    task automatic test_add_wait();
        exec(32'h18918000, 3, -1, -1, "add_wait3");
    endtask

    task automatic test_mul();
        exec(32'h79300000, 0, -1, -1, "mul");
    endtask

    task automatic test_random();
        logic [4:0] ops [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
        for (int k = 0; k < 40; k++) begin
            logic [4:0] op;
            op = ops[$urandom_range(0, 13)];
            exec({op, 27'($urandom)}, int'($urandom_range(0, RDW - 1)), -1, -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        exec(32'h88A00000, 0, -1, -1, "b2b_neg");
        exec(32'hD0000000, 0, -1, -1, "b2b_nop");
        exec(32'h81C80000, 1, -1, -1, "b2b_div");
    endtask

    task automatic test_run_drop();
        exec(32'h18918000, 0, 4, -1, "run_drop");
        check_idle(3, "run_drop_idle");
        run = 1;
        exec(32'h20000000, 0, -1, -1, "after_idle");
    endtask

    task automatic test_wait_boundary();
        exec(32'h30918000, RDW - 1, -1, -1, "wait_max");
    endtask

    task automatic test_timeout();
        exec(32'h18918000, RDW, -1, -1, "timeout");
        do_reset(1'b1, "timeout_clear");
    endtask

    task automatic test_bad_opcode();
        logic [4:0] op;
        exec(32'hF8000000, 0, -1, -1, "bad_11111");
        do_reset(1'b1, "bad_clear");
        do op = 5'($urandom_range(0, 31)); while (kind(op) != 5);
        exec({op, 27'($urandom)}, 0, -1, -1, "bad_random");
        do_reset(1'b1, "bad_random_clear");
    endtask

    task automatic test_halt_and_clear();
        exec(32'hD8000000, 0, -1, -1, "halt");
        do_reset(1'b1, "halt_clear");
        exec(32'h5A1B8000, 0, -1, 4, "clear_in_t4");
        do_reset(1'b1, "t4_clear");
        exec(32'h18918000, 5, -1, 3, "clear_in_t1");
        do_reset(1'b1, "t1_clear");
        exec(32'h18918000, 0, -1, -1, "after_clear");
    endtask

    initial begin
        test_reset();
        test_shl();
        test_add_wait();
        test_mul();
        test_back_to_back();
        test_random();
        test_run_drop();
        test_wait_boundary();
        test_timeout();
        test_bad_opcode();
        test_halt_and_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
